// File: rtl/plic_lite_pkg.sv
// Shared constants and types for the lightweight platform-level interrupt controller.
package plic_lite_pkg;

    localparam int PLIC_NUM_SRC_DEF = 8;
    localparam int PLIC_PRIO_W_DEF  = 3;
    localparam int PLIC_ID_NONE     = 0;

    typedef enum logic {
        GW_LEVEL = 1'b0,
        GW_EDGE  = 1'b1
    } gw_mode_e;

    function automatic int plic_id_w(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/plic_gateway.sv
// One interrupt source: two-flop synchroniser followed by a level or edge gateway
// tracking pending / in-flight / deferred state.
module plic_gateway
    import plic_lite_pkg::*;
#(
    parameter gw_mode_e MODE = GW_LEVEL
) (
    input  logic clk,
    input  logic reset,
    input  logic s_in,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_flight
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;
    logic deferred;
    logic rise;
    logic set_req;

    assign rise    = sync_p1 & ~sync_p2;
    assign set_req = (MODE == GW_EDGE) ? rise : sync_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            sync_p2   <= 1'b0;
            pending   <= 1'b0;
            in_flight <= 1'b0;
            deferred  <= 1'b0;
        end else begin
            // synchroniser stage boundary: sync_p1 is the only value the gateway trusts
            sync_p0 <= s_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;

            if (claim) begin
                pending   <= 1'b0;
                in_flight <= 1'b1;
            end else if (complete && in_flight) begin
                in_flight <= 1'b0;
                // a deferred edge, or one arriving right now, re-pends exactly once
                if ((MODE == GW_EDGE) && (deferred || rise)) begin
                    pending  <= 1'b1;
                    deferred <= 1'b0;
                end
            end else if (!in_flight) begin
                if (set_req) begin
                    pending <= 1'b1;
                end
            end else if ((MODE == GW_EDGE) && rise) begin
                deferred <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/plic_lite.sv
// Parametrised external interrupt controller: per-source gateways, priority arbiter,
// global threshold, MEIP generation and claim/complete handshake.
module plic_lite
    import plic_lite_pkg::*;
#(
    parameter int                 NUM_SRC   = PLIC_NUM_SRC_DEF,
    parameter int                 PRIO_W    = PLIC_PRIO_W_DEF,
    parameter int                 ID_W      = plic_id_w(NUM_SRC),
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               prio_we,
    input  logic [ID_W-1:0]    prio_idx,
    input  logic [PRIO_W-1:0]  prio_wdata,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               thr_we,
    input  logic [PRIO_W-1:0]  thr_wdata,
    input  logic               claim_req,
    output logic               claim_valid,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete_req,
    input  logic [ID_W-1:0]    complete_id,
    output logic               meip
);

    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [NUM_SRC-1:0] en_q;
    logic [PRIO_W-1:0]  thr_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_flight;
    logic [NUM_SRC-1:0] eligible;
    logic [PRIO_W-1:0]  best_prio;
    logic [ID_W-1:0]    best_id;
    logic               irq_hit;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        plic_gateway #(
            .MODE(EDGE_MASK[g] ? GW_EDGE : GW_LEVEL)
        ) u_gw (
            .clk      (clk),
            .reset    (reset),
            .s_in     (src_irq[g]),
            .claim    (claim_req && irq_hit && (best_id == ID_W'(g + 1))),
            .complete (complete_req && (complete_id == ID_W'(g + 1))),
            .pending  (pending[g]),
            .in_flight(in_flight[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                prio_q[i] <= '0;
            end
            en_q  <= '0;
            thr_q <= '0;
        end else begin
            // out-of-range indices (0 or above NUM_SRC) simply match no source
            for (int i = 0; i < NUM_SRC; i++) begin
                if (prio_we && (prio_idx == ID_W'(i + 1))) begin
                    prio_q[i] <= prio_wdata;
                end
            end
            if (en_we) begin
                en_q <= en_wdata;
            end
            if (thr_we) begin
                thr_q <= thr_wdata;
            end
        end
    end

    // strict compare while scanning upward keeps the lowest ID on priority ties
    always_comb begin
        best_prio = '0;
        best_id   = ID_W'(PLIC_ID_NONE);
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending[i] && en_q[i] && (prio_q[i] != '0);
            if (eligible[i] && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                best_id   = ID_W'(i + 1);
            end
        end
    end

    assign irq_hit = best_prio > thr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meip        <= 1'b0;
            claim_valid <= 1'b0;
            claim_id    <= ID_W'(PLIC_ID_NONE);
        end else begin
            meip        <= irq_hit;
            claim_valid <= claim_req;
            if (claim_req) begin
                claim_id <= irq_hit ? best_id : ID_W'(PLIC_ID_NONE);
            end
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Self-checking bench for plic_lite: directed scenarios plus randomized traffic
// compared cycle by cycle against a per-source behavioural model.
module tb_plic_lite;

    localparam int NUM_SRC = 8;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = 4;
    localparam logic [NUM_SRC-1:0] EDGE_MASK = 8'b0101_0000;

    logic               clk;
    logic               reset;
    logic [NUM_SRC-1:0] src_irq;
    logic               prio_we;
    logic [ID_W-1:0]    prio_idx;
    logic [PRIO_W-1:0]  prio_wdata;
    logic               en_we;
    logic [NUM_SRC-1:0] en_wdata;
    logic               thr_we;
    logic [PRIO_W-1:0]  thr_wdata;
    logic               claim_req;
    logic               claim_valid;
    logic [ID_W-1:0]    claim_id;
    logic               complete_req;
    logic [ID_W-1:0]    complete_id;
    logic               meip;

    plic_lite #(
        .NUM_SRC  (NUM_SRC),
        .PRIO_W   (PRIO_W),
        .ID_W     (ID_W),
        .EDGE_MASK(EDGE_MASK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .src_irq     (src_irq),
        .prio_we     (prio_we),
        .prio_idx    (prio_idx),
        .prio_wdata  (prio_wdata),
        .en_we       (en_we),
        .en_wdata    (en_wdata),
        .thr_we      (thr_we),
        .thr_wdata   (thr_wdata),
        .claim_req   (claim_req),
        .claim_valid (claim_valid),
        .claim_id    (claim_id),
        .complete_req(complete_req),
        .complete_id (complete_id),
        .meip        (meip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // reference model: per-source flags indexed by ID, plus the last three sampled inputs
    bit       m_pend [1:NUM_SRC];
    bit       m_inf  [1:NUM_SRC];
    bit       m_def  [1:NUM_SRC];
    int       m_prio [1:NUM_SRC];
    bit       m_en   [1:NUM_SRC];
    int       m_thr;
    logic [NUM_SRC-1:0] h1, h2, h3;
    bit       m_meip;
    bit       m_cv;
    int       m_cid;

    task automatic model_reset();
        for (int i = 1; i <= NUM_SRC; i++) begin
            m_pend[i] = 0; m_inf[i] = 0; m_def[i] = 0; m_prio[i] = 0; m_en[i] = 0;
        end
        m_thr = 0; h1 = '0; h2 = '0; h3 = '0;
        m_meip = 0; m_cv = 0; m_cid = 0;
    endtask

    function automatic bit elig(input int i);
        return m_pend[i] && m_en[i] && (m_prio[i] > 0);
    endfunction

    function automatic int top_prio();
        int p;
        p = 0;
        for (int i = 1; i <= NUM_SRC; i++)
            if (elig(i) && m_prio[i] > p) p = m_prio[i];
        return p;
    endfunction

    function automatic int top_id(input int p);
        int id;
        id = 0;
        if (p > 0)
            for (int i = NUM_SRC; i >= 1; i--)
                if (elig(i) && m_prio[i] == p) id = i;
        return id;
    endfunction

    task automatic model_edge();
        int  bp, cid, cidx;
        bit  is_edge, rise, sync_hi, comp;
        bit  np [1:NUM_SRC];
        bit  ni [1:NUM_SRC];
        bit  nd [1:NUM_SRC];
        bp  = top_prio();
        cid = (claim_req && bp > m_thr) ? top_id(bp) : 0;
        cidx = int'(complete_id);
        for (int i = 1; i <= NUM_SRC; i++) begin
            np[i] = m_pend[i]; ni[i] = m_inf[i]; nd[i] = m_def[i];
            is_edge = EDGE_MASK[i-1];
            sync_hi = h2[i-1];
            rise    = h2[i-1] && !h3[i-1];
            comp    = complete_req && cidx == i && m_inf[i];
            if (cid == i) begin
                np[i] = 0; ni[i] = 1;
            end else if (comp) begin
                ni[i] = 0;
                if (is_edge && (m_def[i] || rise)) begin np[i] = 1; nd[i] = 0; end
            end else if (!m_inf[i]) begin
                if (is_edge ? rise : sync_hi) np[i] = 1;
            end else if (is_edge && rise) begin
                nd[i] = 1;
            end
        end
        m_meip = bp > m_thr;
        m_cv   = claim_req;
        if (claim_req) m_cid = cid;
        for (int i = 1; i <= NUM_SRC; i++) begin
            m_pend[i] = np[i]; m_inf[i] = ni[i]; m_def[i] = nd[i];
        end
        h3 = h2; h2 = h1; h1 = src_irq;
        if (prio_we && int'(prio_idx) >= 1 && int'(prio_idx) <= NUM_SRC)
            m_prio[int'(prio_idx)] = int'(prio_wdata);
        if (en_we)
            for (int i = 1; i <= NUM_SRC; i++) m_en[i] = en_wdata[i-1];
        if (thr_we) m_thr = int'(thr_wdata);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("meip", 32'(meip), 32'(m_meip));
        check("claim_valid", 32'(claim_valid), 32'(m_cv));
        check("claim_id", 32'(claim_id), 32'(m_cid));
        prio_we = 0; en_we = 0; thr_we = 0; claim_req = 0; complete_req = 0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_meip", 32'(meip), 0);
        check("rst_claim_valid", 32'(claim_valid), 0);
        check("rst_claim_id", 32'(claim_id), 0);
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    task automatic set_prio(input int id, input int p);
        prio_idx = ID_W'(id); prio_wdata = PRIO_W'(p); prio_we = 1; tick();
    endtask

    task automatic set_en(input logic [NUM_SRC-1:0] v);
        en_wdata = v; en_we = 1; tick();
    endtask

    task automatic set_thr(input int t);
        thr_wdata = PRIO_W'(t); thr_we = 1; tick();
    endtask

    task automatic do_claim();
        claim_req = 1; tick();
    endtask

    task automatic do_complete(input int id);
        complete_id = ID_W'(id); complete_req = 1; tick();
    endtask

    initial begin
        reset = 1'b1; src_irq = '0;
        prio_we = 0; prio_idx = '0; prio_wdata = '0;
        en_we = 0; en_wdata = '0; thr_we = 0; thr_wdata = '0;
        claim_req = 0; complete_req = 0; complete_id = '0;
        do_reset();

        // level source 3: latency, claim, re-pend after completion
        set_prio(3, 2); set_en(8'h04);
        src_irq[2] = 1'b1;
        wait_n(3);
        check("t1_meip_edge3", 32'(meip), 0);
        tick();
        check("t1_meip_edge4", 32'(meip), 1);
        do_claim();
        check("t1_claim_id", 32'(claim_id), 3);
        check("t1_claim_valid", 32'(claim_valid), 1);
        tick();
        check("t1_valid_drop", 32'(claim_valid), 0);
        check("t1_meip_drop", 32'(meip), 0);
        do_complete(3); wait_n(2);
        check("t1_repend", 32'(meip), 1);
        src_irq = '0; do_reset();

        // priority ordering with a tie resolved toward the lower ID
        set_prio(2, 5); set_prio(6, 5); set_prio(4, 7); set_en(8'h2A);
        src_irq = 8'h2A; wait_n(4);
        do_claim(); check("t2_first", 32'(claim_id), 4);
        do_claim(); check("t2_second", 32'(claim_id), 2);
        do_claim(); check("t2_third", 32'(claim_id), 6);
        do_claim(); check("t2_none", 32'(claim_id), 0);
        src_irq = '0; do_reset();

        // threshold equal to priority masks, one lower lets it through
        set_thr(5); set_prio(1, 5); set_en(8'h01);
        src_irq[0] = 1'b1; wait_n(5);
        check("t3_masked", 32'(meip), 0);
        do_claim(); check("t3_claim_none", 32'(claim_id), 0);
        set_thr(4); tick();
        check("t3_unmasked", 32'(meip), 1);
        src_irq = '0; do_reset();

        // edge source 5: pulses while in flight collapse into one deferred request
        set_prio(5, 3); set_en(8'h10);
        src_irq[4] = 1'b1; tick(); src_irq[4] = 1'b0; wait_n(4);
        check("t4_meip", 32'(meip), 1);
        do_claim(); check("t4_claim1", 32'(claim_id), 5);
        for (int k = 0; k < 3; k++) begin
            src_irq[4] = 1'b1; tick(); src_irq[4] = 1'b0; tick();
        end
        wait_n(4);
        check("t4_inflight_quiet", 32'(meip), 0);
        do_complete(5); tick();
        check("t4_deferred", 32'(meip), 1);
        do_claim(); check("t4_claim2", 32'(claim_id), 5);
        do_complete(5); wait_n(4);
        check("t4_no_more", 32'(meip), 0);
        do_reset();

        // bogus completions leave the in-flight source alone
        set_prio(3, 2); set_en(8'h04);
        src_irq[2] = 1'b1; wait_n(4);
        do_claim(); check("t5_claim", 32'(claim_id), 3);
        do_complete(0); do_complete(9); do_complete(2); wait_n(3);
        check("t5_ignored", 32'(meip), 0);
        do_complete(3); wait_n(2);
        check("t5_real_complete", 32'(meip), 1);

        // reset in the middle of a claim
        set_prio(4, 1); set_en(8'h0C); src_irq[3] = 1'b1; wait_n(4);
        do_claim();
        check("t6_pre_valid", 32'(claim_valid), 1);
        check("t6_pre_id", 32'(claim_id), 3);
        do_reset();
        wait_n(6);
        check("t6_no_meip", 32'(meip), 0);
        do_claim(); check("t6_no_claim", 32'(claim_id), 0);
        set_prio(3, 2); set_en(8'h04); tick();
        check("t6_reprogrammed", 32'(meip), 1);
        src_irq = '0; do_reset();

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) do_reset();
            if ($urandom_range(0, 2) == 0) src_irq[$urandom_range(0, NUM_SRC-1)] ^= 1'b1;
            prio_we    = ($urandom_range(0, 7) == 0);
            prio_idx   = ID_W'($urandom_range(0, 10));
            prio_wdata = PRIO_W'($urandom);
            en_we      = ($urandom_range(0, 31) == 0);
            en_wdata   = NUM_SRC'($urandom);
            thr_we     = ($urandom_range(0, 31) == 0);
            thr_wdata  = PRIO_W'($urandom_range(0, 7));
            claim_req  = ($urandom_range(0, 3) == 0);
            complete_req = ($urandom_range(0, 2) == 0);
            complete_id  = ID_W'($urandom_range(0, 10));
            if ($urandom_range(0, 1) == 0)
                for (int i = 1; i <= NUM_SRC; i++)
                    if (m_inf[i]) complete_id = ID_W'(i);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
